// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment order everywhere is {g,f,e,d,c,b,a}, active-high in this package.
package seg7_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to {g..a} segment decoder with output polarity applied.
module seg7_hex_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [6:0] seg_hi;

  assign seg_hi = hex_to_seg(nibble);
  assign seg    = ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: per digit an all-off BLANK dead-time, then a
// DRIVE dwell with segment data latched on entry. All outputs are registered.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int IDX_W       = $clog2(NUM_DIGITS),
  parameter int CLK_DIV     = 100000,
  parameter int DEAD_CYCLES = 16,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [IDX_W-1:0]        seg_sel,
  output logic [6:0]              cathodes,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CNT_MAX = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DRIVE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
  localparam logic                  DP_OFF     = ACTIVE_LOW;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]              cathodes_q, cathodes_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic [3:0]              nib_sel;
  logic                    dp_sel;
  logic                    blank_sel;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic [6:0]              seg_dec;

  // Per-digit input selection for the digit currently slotted.
  always_comb begin
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_hot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel   = data_in[4*i +: 4];
        dp_sel    = dp_in[i];
        blank_sel = blank_in[i];
        an_hot[i] = 1'b1;
      end
    end
  end

  seg7_hex_decoder #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_hex_decoder (
    .nibble(nib_sel),
    .seg   (seg_dec)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    anodes_d     = anodes_q;
    cathodes_d   = cathodes_q;
    dp_d         = dp_q;
    frame_done_d = 1'b0;

    if (!enable) begin
      state_d    = OFF;
      cnt_d      = '0;
      idx_d      = '0;
      anodes_d   = AN_OFF;
      cathodes_d = SEG_OFF;
      dp_d       = DP_OFF;
    end else begin
      case (state_q)
        OFF: begin
          state_d    = BLANK;
          cnt_d      = '0;
          idx_d      = '0;
          anodes_d   = AN_OFF;
          cathodes_d = SEG_OFF;
          dp_d       = DP_OFF;
        end
        BLANK: begin
          anodes_d = AN_OFF;
          if (cnt_q == DEAD_LAST) begin
            // Latch point: inputs are sampled here and held for the whole dwell.
            state_d    = DRIVE;
            cnt_d      = '0;
            anodes_d   = blank_sel ? AN_OFF : (ACTIVE_LOW ? ~an_hot : an_hot);
            cathodes_d = seg_dec;
            dp_d       = dp_sel ? ~DP_OFF : DP_OFF;
          end
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d      = BLANK;
            cnt_d        = '0;
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            anodes_d     = AN_OFF;
            cathodes_d   = SEG_OFF;
            dp_d         = DP_OFF;
            frame_done_d = (idx_q == IDX_LAST);
          end
        end
        default: begin
          state_d    = OFF;
          cnt_d      = '0;
          idx_d      = '0;
          anodes_d   = AN_OFF;
          cathodes_d = SEG_OFF;
          dp_d       = DP_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= OFF;
      cnt_q        <= '0;
      idx_q        <= '0;
      anodes_q     <= AN_OFF;
      cathodes_q   <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      anodes_q     <= anodes_d;
      cathodes_q   <= cathodes_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anodes     = anodes_q;
  assign seg_sel    = idx_q;
  assign cathodes   = cathodes_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a 4-digit active-low instance and an 8-digit active-high
// instance, both checked every cycle against a slot-arithmetic reference model.
module tb_seg7_scan_ctrl;

  localparam int T_DEAD = 2;
  localparam int T_DIV  = 4;
  localparam int T_P    = T_DEAD + T_DIV;

  logic        clk;
  logic        reset;
  logic        enable_a, enable_b;
  logic [15:0] data_a;
  logic [3:0]  dp_a, blank_a;
  logic [3:0]  an_a;
  logic [1:0]  sel_a;
  logic [6:0]  cath_a;
  logic        dp_o_a, fd_a;
  logic [31:0] data_b;
  logic [7:0]  dp_b, blank_b;
  logic [7:0]  an_b;
  logic [2:0]  sel_b;
  logic [6:0]  cath_b;
  logic        dp_o_b, fd_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  logic [6:0] hex_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  int         t_m [2] = '{0, 0};
  logic [6:0] lat_seg [2] = '{7'h0, 7'h0};
  logic       lat_dp [2] = '{1'b0, 1'b0};
  logic       lat_blk [2] = '{1'b0, 1'b0};

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .CLK_DIV(T_DIV), .DEAD_CYCLES(T_DEAD), .ACTIVE_LOW(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .data_in(data_a), .dp_in(dp_a),
    .blank_in(blank_a), .anodes(an_a), .seg_sel(sel_a), .cathodes(cath_a),
    .dp(dp_o_a), .frame_done(fd_a)
  );

  seg7_scan_ctrl #(
    .NUM_DIGITS(8), .CLK_DIV(T_DIV), .DEAD_CYCLES(T_DEAD), .ACTIVE_LOW(1'b0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .data_in(data_b), .dp_in(dp_b),
    .blank_in(blank_b), .anodes(an_b), .seg_sel(sel_b), .cathodes(cath_b),
    .dp(dp_o_b), .frame_done(fd_b)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: t = edges since scanning (re)started; slot and digit follow by division.
  task automatic model_edge(input int inst, input logic en, input logic [31:0] data,
                            input logic [7:0] dpv, input logic [7:0] blk);
    int n, s, k, d;
    bit al;
    logic [15:0] off_an, an;
    logic [6:0] cath;
    logic dpo, fd;
    n = (inst == 0) ? 4 : 8;
    al = (inst == 0);
    off_an = al ? 16'((32'h1 << n) - 1) : 16'h0;
    if (reset || !en) t_m[inst] = 0;
    else t_m[inst]++;
    an = off_an;
    cath = al ? 7'h7f : 7'h00;
    dpo = al;
    fd = 1'b0;
    d = 0;
    if (t_m[inst] > 0) begin
      s = (t_m[inst] - 1) % T_P;
      k = (t_m[inst] - 1) / T_P;
      d = k % n;
      if (s == T_DEAD) begin
        lat_seg[inst] = hex_tab[data[4*d +: 4]];
        lat_dp[inst]  = dpv[d];
        lat_blk[inst] = blk[d];
      end
      if (s < T_DEAD) begin
        fd = (s == 0) && (k >= 1) && (d == 0);
      end else begin
        if (!lat_blk[inst]) an = al ? (off_an & ~(16'h1 << d)) : (16'h1 << d);
        cath = al ? ~lat_seg[inst] : lat_seg[inst];
        dpo = lat_dp[inst] ^ al;
      end
    end
    exp_q.push_back({3'b0, fd, dpo, cath, 4'(d), an});
  endtask

  // Driver + scoreboard: predict from inputs held across the edge, then compare.
  task automatic step();
    logic [31:0] w;
    model_edge(0, enable_a, 32'(data_a), 8'(dp_a), 8'(blank_a));
    model_edge(1, enable_b, data_b, dp_b, blank_b);
    @(posedge clk);
    #1;
    w = exp_q.pop_front();
    check_val("an_a", 32'(an_a), 32'(w[15:0]));
    check_val("sel_a", 32'(sel_a), 32'(w[19:16]));
    check_val("cath_a", 32'(cath_a), 32'(w[26:20]));
    check_val("dp_a", 32'(dp_o_a), 32'(w[27]));
    check_val("fd_a", 32'(fd_a), 32'(w[28]));
    check_val("onehot_a", 32'($countones(~an_a) <= 1), 32'd1);
    w = exp_q.pop_front();
    check_val("an_b", 32'(an_b), 32'(w[15:0]));
    check_val("sel_b", 32'(sel_b), 32'(w[19:16]));
    check_val("cath_b", 32'(cath_b), 32'(w[26:20]));
    check_val("dp_b", 32'(dp_o_b), 32'(w[27]));
    check_val("fd_b", 32'(fd_b), 32'(w[28]));
    check_val("onehot_b", 32'($countones(an_b) <= 1), 32'd1);
  endtask

  // Step until instance a is in DRIVE cycle 'sub' of the given digit.
  task automatic wait_drive(input int digit, input int sub);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (t_m[0] > 0 && ((t_m[0] - 1) % T_P) == T_DEAD + sub &&
          (((t_m[0] - 1) / T_P) % 4) == digit) begin
        found = 1'b1;
        break;
      end
    end
    check_val("wait_drive", 32'(found), 32'd1);
  endtask

  task automatic measure_frame(input string tag);
    int first, second;
    first = -1;
    second = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (fd_a) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check_val(tag, 32'(second - first), 32'd24);
  endtask

  initial begin
    logic [6:0] lit [4];
    lit[0] = 7'b1111001;
    lit[1] = 7'b0000000;
    lit[2] = 7'b0001000;
    lit[3] = 7'b0110000;
    reset = 1'b1;
    enable_a = 1'b0;
    enable_b = 1'b0;
    data_a = 16'h0;
    dp_a = 4'h0;
    blank_a = 4'h0;
    data_b = 32'h0;
    dp_b = 8'h0;
    blank_b = 8'h0;

    for (int i = 0; i < 3; i++) step();
    check_val("rst_an", 32'(an_a), 32'hf);
    check_val("rst_cath", 32'(cath_a), 32'h7f);
    check_val("rst_dp", 32'(dp_o_a), 32'd1);
    check_val("rst_an_b", 32'(an_b), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) step();

    // Basic scan
    data_a = 16'h3A81;
    enable_a = 1'b1;
    enable_b = 1'b1;
    step();
    step();
    check_val("basic_dark", 32'(an_a), 32'hf);
    step();
    check_val("basic_an0", 32'(an_a), 32'b1110);
    check_val("basic_cath0", 32'(cath_a), 32'(lit[0]));
    check_val("b_an0", 32'(an_b), 32'h01);
    check_val("b_cath0", 32'(cath_b), 32'b0111111);
    for (int dg = 1; dg < 4; dg++) begin
      wait_drive(dg, 0);
      check_val("basic_an", 32'(an_a), 32'(4'hf & ~(4'h1 << dg)));
      check_val("basic_cath", 32'(cath_a), 32'(lit[dg]));
    end
    measure_frame("basic_period");

    // Blank and dp
    blank_a = 4'b0100;
    dp_a = 4'b0001;
    wait_drive(2, 0);
    check_val("blank_d2", 32'(an_a), 32'hf);
    wait_drive(0, 0);
    check_val("dp_d0", 32'(dp_o_a), 32'd0);
    measure_frame("blank_period");

    // Mid-slot data change
    wait_drive(0, 1);
    data_a[3:0] = 4'hF;
    step();
    check_val("hold_old", 32'(cath_a), 32'b1111001);
    wait_drive(0, 0);
    check_val("new_frame", 32'(cath_a), 32'b0001110);

    // Disable mid digit 2
    wait_drive(2, 1);
    enable_a = 1'b0;
    step();
    check_val("dis_an", 32'(an_a), 32'hf);
    check_val("dis_cath", 32'(cath_a), 32'h7f);
    check_val("dis_sel", 32'(sel_a), 32'd0);
    enable_a = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_val("reen_an", 32'(an_a), 32'b1110);

    // Reset mid digit 2
    wait_drive(2, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("rstm_an", 32'(an_a), 32'hf);
    check_val("rstm_cath", 32'(cath_a), 32'h7f);
    check_val("rstm_sel", 32'(sel_a), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check_val("rstm_an0", 32'(an_a), 32'b1110);

    // Randomized traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 15) == 0) data_a = 16'($urandom);
      if ($urandom_range(0, 15) == 0) data_b = $urandom;
      if ($urandom_range(0, 31) == 0) dp_a = 4'($urandom);
      if ($urandom_range(0, 31) == 0) dp_b = 8'($urandom);
      if ($urandom_range(0, 31) == 0) blank_a = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_b = 8'($urandom);
      if (enable_a) enable_a = ($urandom_range(0, 149) != 0);
      else enable_a = ($urandom_range(0, 3) == 0);
      if (enable_b) enable_b = ($urandom_range(0, 149) != 0);
      else enable_b = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
